// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - coin-slot pulse width classifier feeding the vending FSM
//
// Synchronises the raw coin sensor, measures each high pulse in clock cycles
// and emits a one-cycle coin code (1 = one-unit, 2 = two-unit) or a one-cycle
// reject. A hold-off window after every pulse absorbs contact bounce.
//
// Optional feature: define COIN_ACC_REJECT_CNT_EN to add the rej_cnt port,
// a saturating 8-bit count of reject pulses.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset
//   sensor   in   raw asynchronous coin sensor, high while a coin passes
//   enable   in   allows a new measurement to start
//   coin     out  coin code, valid for one cycle, 0 otherwise
//   reject   out  one-cycle pulse per rejected pulse
//   busy     out  high while the FSM is not IDLE
//   rej_cnt  out  saturating reject count (COIN_ACC_REJECT_CNT_EN only)

module coin_acceptor #(
    parameter int MIN1  = 2,
    parameter int MAX1  = 4,
    parameter int MIN2  = 6,
    parameter int MAX2  = 9,
    parameter int GAP   = 3,
    parameter int CNT_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor,
    input  logic       enable,
    output logic [1:0] coin,
    output logic       reject,
    output logic       busy
`ifdef COIN_ACC_REJECT_CNT_EN
    ,
    output logic [7:0] rej_cnt
`endif
);

    localparam int HW = $clog2(GAP + 1);

    localparam logic [CNT_W-1:0] MIN1_C = CNT_W'(MIN1);
    localparam logic [CNT_W-1:0] MAX1_C = CNT_W'(MAX1);
    localparam logic [CNT_W-1:0] MIN2_C = CNT_W'(MIN2);
    localparam logic [CNT_W-1:0] MAX2_C = CNT_W'(MAX2);
    localparam logic [HW-1:0]    GAP_C  = HW'(GAP);
    localparam logic [HW-1:0]    HONE_C = HW'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STUCK   = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [HW-1:0]    hcnt_q, hcnt_d;
    logic             s1, s2;
    // Set while a pulse seen in IDLE with enable low is still high, so that
    // raising enable part-way through it cannot start a bogus measurement.
    logic             ign_q, ign_d;
    logic [1:0]       coin_d;
    logic             reject_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            state_q <= HOLDOFF;
            cnt_q   <= '0;
            hcnt_q  <= GAP_C;
            ign_q   <= 1'b0;
            coin    <= 2'd0;
            reject  <= 1'b0;
            busy    <= 1'b1;
        end else begin
            s1      <= sensor;
            s2      <= s1;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hcnt_q  <= hcnt_d;
            ign_q   <= ign_d;
            coin    <= coin_d;
            reject  <= reject_d;
            busy    <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hcnt_d   = hcnt_q;
        ign_d    = 1'b0;
        coin_d   = 2'd0;
        reject_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s2 && enable && !ign_q) begin
                    state_d = MEASURE;
                    cnt_d   = CNT_W'(1);
                end else begin
                    ign_d = s2;
                end
            end
            MEASURE: begin
                if (s2) begin
                    if (cnt_q == MAX2_C) begin
                        reject_d = 1'b1;
                        state_d  = STUCK;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    if (cnt_q >= MIN1_C && cnt_q <= MAX1_C) begin
                        coin_d = 2'd1;
                    end else if (cnt_q >= MIN2_C && cnt_q <= MAX2_C) begin
                        coin_d = 2'd2;
                    end else begin
                        reject_d = 1'b1;
                    end
                    state_d = HOLDOFF;
                    hcnt_d  = GAP_C;
                end
            end
            STUCK: begin
                if (!s2) begin
                    state_d = HOLDOFF;
                    hcnt_d  = GAP_C;
                end
            end
            HOLDOFF: begin
                if (s2) begin
                    hcnt_d = GAP_C;
                end else if (hcnt_q == HONE_C) begin
                    state_d = IDLE;
                    hcnt_d  = GAP_C;
                end else begin
                    hcnt_d = hcnt_q - HONE_C;
                end
            end
            default: state_d = HOLDOFF;
        endcase
    end

`ifdef COIN_ACC_REJECT_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rej_cnt <= 8'd0;
        end else if (reject && rej_cnt != 8'hFF) begin
            rej_cnt <= rej_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - directed self-checking bench for coin_acceptor

module tb_coin_acceptor;

    logic       clk;
    logic       reset;
    logic       sensor;
    logic       enable;
    logic [1:0] coin;
    logic       reject;
    logic       busy;
`ifdef COIN_ACC_REJECT_CNT_EN
    logic [7:0] rej_cnt;
`endif

    coin_acceptor dut (
        .clk    (clk),
        .reset  (reset),
        .sensor (sensor),
        .enable (enable),
        .coin   (coin),
        .reject (reject),
        .busy   (busy)
`ifdef COIN_ACC_REJECT_CNT_EN
        ,
        .rej_cnt(rej_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_pass;

    int   cyc;
    int   n_coin;
    int   n_rej;
    int   n_consec;
    int   coin_cyc;
    int   rej_cyc;
    int   busy_rise;
    int   busy_fall;
    logic [1:0] coin_code;
    logic prev_busy;
    logic prev_out;

    task automatic clear_stats();
        cyc       = 0;
        n_coin    = 0;
        n_rej     = 0;
        n_consec  = 0;
        coin_cyc  = -1;
        rej_cyc   = -1;
        busy_rise = -1;
        busy_fall = -1;
        coin_code = 2'd0;
        prev_busy = busy;
        prev_out  = 1'b0;
    endtask

    // One clock: drive inputs, let the edge pass, then record output events.
    task automatic tick(input logic s, input logic r);
        sensor = s;
        reset  = r;
        @(posedge clk);
        #1;
        cyc++;
        if (coin !== 2'd0) begin
            n_coin++;
            coin_cyc  = cyc;
            coin_code = coin;
        end
        if (reject === 1'b1) begin
            n_rej++;
            rej_cyc = cyc;
        end
        if (((coin !== 2'd0) || (reject === 1'b1)) && prev_out) n_consec++;
        prev_out = (coin !== 2'd0) || (reject === 1'b1);
        if (prev_busy === 1'b1 && busy === 1'b0) busy_fall = cyc;
        if (prev_busy === 1'b0 && busy === 1'b1) busy_rise = cyc;
        prev_busy = busy;
    endtask

    task automatic pulse(input int w, input int low);
        for (int i = 0; i < w; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < low; i++) tick(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        logic [2:0] exp_busy;
        exp_busy = 3'b011;
        clear_stats();
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        n_checks++;
        if (busy !== 1'b1 || coin !== 2'd0 || reject !== 1'b0)
            $display("FAIL reset_state busy=%b coin=%0d reject=%b exp busy=1 coin=0 reject=0", busy, coin, reject);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0);
            n_checks++;
            if (busy !== exp_busy[i] || coin !== 2'd0 || reject !== 1'b0)
                $display("FAIL reset_release%0d busy=%b coin=%0d reject=%b exp busy=%b coin=0 reject=0",
                         i, busy, coin, reject, exp_busy[i]);
            else n_pass++;
        end
`ifdef COIN_ACC_REJECT_CNT_EN
        n_checks++;
        if (rej_cnt !== 8'd0) $display("FAIL reset_rej_cnt got %0d exp 0", rej_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_widths();
        int w_tab [9];
        int k_tab [9];
        int c_tab [9];
        int f_tab [9];
        w_tab = '{3, 7, 1, 5, 10, 2, 4, 6, 9};
        k_tab = '{1, 2, 0, 0, 0, 1, 1, 2, 2};
        c_tab = '{6, 10, 4, 8, 12, 5, 7, 9, 12};
        f_tab = '{9, 13, 7, 11, 16, 8, 10, 12, 15};
        for (int i = 0; i < 9; i++) begin
            clear_stats();
            pulse(w_tab[i], 10);
            n_checks++;
            if (n_coin + n_rej !== 1)
                $display("FAIL width%0d event_count got %0d exp 1", w_tab[i], n_coin + n_rej);
            else n_pass++;
            n_checks++;
            if (k_tab[i] == 0) begin
                if (n_rej !== 1 || n_coin !== 0)
                    $display("FAIL width%0d kind got coins=%0d rejects=%0d exp reject", w_tab[i], n_coin, n_rej);
                else n_pass++;
            end else begin
                if (n_coin !== 1 || int'(coin_code) !== k_tab[i] || n_rej !== 0)
                    $display("FAIL width%0d kind got code=%0d rejects=%0d exp code=%0d", w_tab[i], coin_code, n_rej, k_tab[i]);
                else n_pass++;
            end
            n_checks++;
            if ((k_tab[i] == 0 ? rej_cyc : coin_cyc) !== c_tab[i])
                $display("FAIL width%0d event_cycle got %0d exp %0d", w_tab[i],
                         (k_tab[i] == 0 ? rej_cyc : coin_cyc), c_tab[i]);
            else n_pass++;
            n_checks++;
            if (busy_fall !== f_tab[i] || busy_rise !== 3)
                $display("FAIL width%0d busy got rise=%0d fall=%0d exp rise=3 fall=%0d",
                         w_tab[i], busy_rise, busy_fall, f_tab[i]);
            else n_pass++;
`ifdef COIN_ACC_REJECT_CNT_EN
            if (i == 4) begin
                n_checks++;
                if (rej_cnt !== 8'd3) $display("FAIL rej_cnt_after_three got %0d exp 3", rej_cnt);
                else n_pass++;
            end
`endif
        end
    endtask

    task automatic test_overlong();
        clear_stats();
        pulse(15, 10);
        n_checks++;
        if (n_rej !== 1 || n_coin !== 0)
            $display("FAIL overlong_count got rejects=%0d coins=%0d exp 1 0", n_rej, n_coin);
        else n_pass++;
        n_checks++;
        if (rej_cyc !== 12) $display("FAIL overlong_reject_cycle got %0d exp 12", rej_cyc);
        else n_pass++;
        n_checks++;
        if (busy_fall !== 21) $display("FAIL overlong_busy_fall got %0d exp 21", busy_fall);
        else n_pass++;
        n_checks++;
        if (n_consec !== 0) $display("FAIL overlong_consecutive got %0d exp 0", n_consec);
        else n_pass++;
`ifdef COIN_ACC_REJECT_CNT_EN
        n_checks++;
        if (rej_cnt !== 8'd4) $display("FAIL overlong_rej_cnt got %0d exp 4", rej_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_back_to_back();
        clear_stats();
        pulse(3, 1);
        pulse(3, 10);
        n_checks++;
        if (n_coin !== 1 || coin_code !== 2'd1 || n_rej !== 0)
            $display("FAIL bounce_events got coins=%0d code=%0d rejects=%0d exp 1 1 0", n_coin, coin_code, n_rej);
        else n_pass++;
        n_checks++;
        if (coin_cyc !== 6) $display("FAIL bounce_coin_cycle got %0d exp 6", coin_cyc);
        else n_pass++;
        n_checks++;
        if (busy_fall !== 12) $display("FAIL bounce_busy_fall got %0d exp 12", busy_fall);
        else n_pass++;
    endtask

    task automatic test_enable();
        clear_stats();
        enable = 1'b0;
        pulse(3, 8);
        n_checks++;
        if (n_coin + n_rej !== 0 || busy_rise !== -1)
            $display("FAIL enable_low got events=%0d busy_rise=%0d exp 0 -1", n_coin + n_rej, busy_rise);
        else n_pass++;

        clear_stats();
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        enable = 1'b1;
        pulse(3, 8);
        n_checks++;
        if (n_coin + n_rej !== 0 || busy_rise !== -1)
            $display("FAIL enable_mid_rise got events=%0d busy_rise=%0d exp 0 -1", n_coin + n_rej, busy_rise);
        else n_pass++;

        clear_stats();
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        enable = 1'b0;
        pulse(0, 10);
        enable = 1'b1;
        n_checks++;
        if (n_coin !== 1 || coin_code !== 2'd1 || coin_cyc !== 6 || n_rej !== 0)
            $display("FAIL enable_mid_fall got coins=%0d code=%0d cycle=%0d rejects=%0d exp 1 1 6 0",
                     n_coin, coin_code, coin_cyc, n_rej);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        clear_stats();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        pulse(0, 10);
        n_checks++;
        if (n_coin + n_rej !== 0)
            $display("FAIL reset_mid_events got %0d exp 0", n_coin + n_rej);
        else n_pass++;
        n_checks++;
        if (busy_fall !== 11) $display("FAIL reset_mid_busy_fall got %0d exp 11", busy_fall);
        else n_pass++;
        clear_stats();
        pulse(3, 10);
        n_checks++;
        if (n_coin !== 1 || coin_code !== 2'd1 || coin_cyc !== 6 || n_rej !== 0)
            $display("FAIL reset_mid_next got coins=%0d code=%0d cycle=%0d rejects=%0d exp 1 1 6 0",
                     n_coin, coin_code, coin_cyc, n_rej);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        sensor   = 1'b0;
        enable   = 1'b1;
        test_reset();
        test_widths();
        test_overlong();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end stage that sits directly upstream of `vending_machine_FSM`. It synchronises the raw coin-slot sensor, measures the width of each sensor pulse, classifies it, and emits a one-cycle coin code on `coin[1:0]`: 1 = one-unit coin, 2 = two-unit coin, 0 = no coin. Malformed, overlong or bouncing pulses are rejected and never reach the vending FSM.

## Interface
- `MIN1`, default 2: minimum width, in cycles, of a one-unit pulse.
- `MAX1`, default 4: maximum width of a one-unit pulse.
- `MIN2`, default 6: minimum width of a two-unit pulse.
- `MAX2`, default 9: maximum width of a two-unit pulse.
- `GAP`, default 3: hold-off cycles after a pulse. Must be ≥ 2.
- `CNT_W`, default 4: counter width. Must hold MAX2+1.
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sensor`  in  1  raw, asynchronous coin-slot sensor; high while a coin passes.
- `enable`  in  1  allows a new measurement to start.
- `coin`  out  2  coin code, valid for one cycle; 0 otherwise. Feeds `vending_machine_FSM.coin`.
- `reject`  out  1  one-cycle pulse for each rejected pulse.
- `busy`  out  1  high when the state is not IDLE.

## Operation
- `sensor` passes through a 2-flop synchroniser (s1, s2). All decisions below use s2.
- States:
  - **IDLE**: on s2=1 with `enable`=1, go to MEASURE with cnt=1. On s2=1 with `enable`=0, stay in IDLE; that pulse is ignored for its whole length.
  - **MEASURE**:
    - s2=1 and cnt<MAX2: cnt++.
    - s2=1 and cnt=MAX2: `reject`=1 and go to STUCK.
    - s2=0: classify cnt and go to HOLDOFF with hcnt=GAP.
- Classification:
  - MIN1≤cnt≤MAX1 gives `coin`=1.
  - MIN2≤cnt≤MAX2 gives `coin`=2.
  - Any other width gives `reject`=1 and `coin`=0.
  - Exactly one of `coin`≠0 or `reject` pulses per measured pulse.
- **STUCK**: wait for s2=0, then go to HOLDOFF with hcnt=GAP. No further outputs.
- **HOLDOFF**:
  - s2=1: reload hcnt=GAP (bounce is absorbed, no output).
  - s2=0: hcnt--.
  - Leave for IDLE on the edge where hcnt=1 and s2=0.
- Clearing `enable` mid-pulse does not abort it. An in-flight MEASURE completes and is classified normally.
- Outputs are registered. `coin` and `reject` are never high for two consecutive cycles.
- Reset values:
  - State = HOLDOFF, hcnt=GAP, cnt=0, s1=s2=0.
  - `coin`=0, `reject`=0, `busy`=1.
  - Starting in HOLDOFF means a sensor already high at reset release is absorbed as bounce and never counted.
- Reset mid-MEASURE discards the partial pulse; no `coin` or `reject` is emitted for it.

## Timing
- Latency: if `sensor` is first sampled low at edge t, `coin`/`reject` go high at edge t+2 and low at edge t+3.
- Width: cnt equals the number of consecutive edges at which s2=1. With a clean input, this equals the number of edges at which `sensor` was sampled high.
- Overlong pulse: `reject` rises at the edge where cnt=MAX2 and s2 is still 1 (the (MAX2+1)th high sample), two edges after the raw sample.
- Minimum spacing: a coin end to the next accepted coin start needs GAP low cycles at s2. Pulses starting sooner extend HOLDOFF and are lost.
- `busy` falls on the same edge the FSM enters IDLE.

## Configuration
- Macro: `COIN_ACC_REJECT_CNT_EN`.
- When defined:
  - Adds port `rej_cnt` (out, 8 bits): a saturating count of `reject` pulses.
  - It increments on the edge after each `reject` pulse and holds at 255.
  - It is cleared by `reset` only.
- When undefined, the port and counter are absent, and all other behaviour is identical.

## Test plan
All scenarios use the default parameters.
- Reset for 2 cycles, then release: `busy`=1 for 3 cycles, then 0. `coin`=0 and `reject`=0 throughout.
- `sensor` high for 3 cycles → `coin`=1 for exactly one cycle, 2 edges after the first low sample. `reject` stays 0. Repeat with 7 cycles high → `coin`=2.
- Widths 1, 5 and 10 → `reject` pulses once each, `coin` stays 0. With the macro, `rej_cnt` reads 3.
- `sensor` high for 15 cycles → a single `reject` at the 10th high sample edge plus 2. `busy` stays high until 3 low cycles after the fall. No second pulse.
- High 3, low 1, high 3, then low → exactly one `coin`=1. The second pulse is absorbed, and `busy` falls 3 cycles after the final fall.
- Reset asserted after 2 high samples while `sensor` stays high 4 more cycles → no `coin` or `reject` for that pulse. A subsequent clean 3-cycle pulse yields `coin`=1.
